dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit storage words.
REQ-002 Parameter BASE_ADDR, default 32'h0: byte address of storage word 0.
REQ-003 Parameter WAIT_CYCLES, default 1, range 0..15: wait states inserted per access.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset_x  in  1  reset, asynchronous, active-low.
REQ-006 i_req  in  1  access request from pipeline MEM stage.
REQ-007 i_write  in  1  1 = store, 0 = load; sampled with i_req.
REQ-008 i_addr  in  32  byte address (pipeline ALU result).
REQ-009 i_wdata  in  32  store data, right-justified.
REQ-010 i_memSize  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-011 o_rdata  out  32  load data, right-justified, upper bits zero; pipeline performs sign/zero extension.
REQ-012 o_stall  out  1  to hazard unit; requester holds all inputs stable while high.
REQ-013 o_done  out  1  one-cycle completion pulse.
REQ-014 o_misaligned  out  1  alignment error flag, valid with o_done.
REQ-015 o_outOfRange  out  1  address error flag, valid with o_done.

Function
REQ-016 FSM states IDLE, WAIT, RESP; encoding free.
REQ-017 IDLE: i_req=1 accepts request; o_stall=1 combinationally in that cycle; next state WAIT if WAIT_CYCLES>0, else RESP.
REQ-018 IDLE with i_req=0: remain IDLE, o_stall=0.
REQ-019 WAIT: 4-bit counter loaded with WAIT_CYCLES-1 on entry, decremented each cycle; at 0 -> RESP; o_stall=1 throughout.
REQ-020 RESP: exactly one cycle; o_done=1, o_stall=0; next state always IDLE; i_req in RESP ignored.
REQ-021 Latency: request first seen in IDLE cycle N -> o_done in cycle N+1+WAIT_CYCLES.
REQ-022 Store performed at the edge entering RESP, using inputs held at that edge.
REQ-023 Load data registered at the edge entering RESP; o_rdata valid only while o_done=1, 32'h0 otherwise.
REQ-024 Word index = (i_addr-BASE_ADDR)>>2; lane = i_addr[1:0].
REQ-025 Byte store writes only lane i_addr[1:0] with i_wdata[7:0]; half store writes lanes {a[1],0} and {a[1],1} with i_wdata[15:0], little-endian; word store writes all lanes.
REQ-026 Byte load returns selected lane in [7:0]; half load returns selected halfword in [15:0]; word load returns full word.
REQ-027 Misaligned: half with a[0]=1, or word/11 with a[1:0]!=0 -> no store, o_rdata=0, o_misaligned=1 in RESP.
REQ-028 Out of range: i_addr<BASE_ADDR or (i_addr-BASE_ADDR)>=DEPTH_WORDS*4 -> no store, o_rdata=0, o_outOfRange=1 in RESP; both flags may assert together.
REQ-029 Full access timing (WAIT, RESP) applies to error cases as well.
REQ-030 Back-to-back: request after RESP is accepted no earlier than the following IDLE cycle; minimum request spacing 2+WAIT_CYCLES cycles.
REQ-031 Load immediately following store to same word returns the stored value.

Reset
REQ-032 reset_x=0 forces IDLE, counter 0, o_rdata=0, o_done=0, o_misaligned=0, o_outOfRange=0, o_stall=0 asynchronously.
REQ-033 Reset in WAIT aborts the access; no store occurs.
REQ-034 Storage array not reset; contents after reset undefined until written.

Verification
REQ-035 WAIT_CYCLES=1: word store 32'hDEADBEEF @0x10, then word load @0x10 -> o_stall high 2 cycles each, o_done 2 cycles after request, o_rdata=32'hDEADBEEF.
REQ-036 Byte stores 8'h11,8'h22,8'h33,8'h44 @0x20..0x23, then half load @0x22 -> o_rdata=32'h00004433; word load @0x20 -> 32'h44332211.
REQ-037 Word store @0x06 after word 0x04 holds 32'hCAFEF00D -> o_misaligned=1, o_rdata=0, word 0x04 still 32'hCAFEF00D.
REQ-038 Word load @DEPTH_WORDS*4 (0x1000 default) -> o_outOfRange=1, o_rdata=0, o_misaligned=0.
REQ-039 WAIT_CYCLES=3: store request, reset_x pulsed low during WAIT -> all outputs 0 immediately, target word unchanged on later load.
REQ-040 WAIT_CYCLES=0: i_req held continuously -> o_done every second cycle, o_stall alternating 1/0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated single-port data memory responder for a pipeline MEM stage
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        i_req,
    input  logic        i_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_memSize,
    output logic [31:0] o_rdata,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_misaligned,
    output logic        o_outOfRange
);
    localparam int unsigned IW    = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WLOAD = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   off;
    logic [31:0]   rd_word;
    logic [31:0]   ld_data;
    logic [31:0]   st_data;
    logic [IW-1:0] idx;
    logic [3:0]    be;
    logic [1:0]    lane;
    logic          mis;
    logic          oor;
    logic          go_resp;

    // address decode, error detection, lane steering for loads and stores
    always_comb begin
        off     = i_addr - BASE_ADDR;
        idx     = off[IW+1:2];
        lane    = i_addr[1:0];
        oor     = (i_addr < BASE_ADDR) || ({1'b0, off} >= SPAN);
        mis     = (i_memSize == 2'b01 && i_addr[0]) || (i_memSize[1] && lane != 2'b00);
        rd_word = oor ? 32'h0 : mem[idx];
        ld_data = i_memSize == 2'b00 ? {24'h0, rd_word[{lane, 3'b000} +: 8]} :
                  i_memSize == 2'b01 ? {16'h0, rd_word[{lane[1], 4'b0000} +: 16]} : rd_word;
        be      = i_memSize == 2'b00 ? 4'b0001 << lane :
                  i_memSize == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        st_data = i_memSize == 2'b00 ? {4{i_wdata[7:0]}} :
                  i_memSize == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
        go_resp = (state == IDLE && i_req && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
    end

    // stall covers the accepting IDLE cycle and every wait cycle; forced low in reset
    assign o_stall = reset_x && ((state == IDLE && i_req) || state == WAIT);

    // storage write happens on the edge entering RESP; the array is never reset
    always_ff @(posedge clk)
        if (go_resp && i_write && !mis && !oor)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];

    // access sequencing and registered response outputs
    always_ff @(posedge clk or negedge reset_x)
        if (!reset_x) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            o_rdata      <= 32'h0;
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            o_outOfRange <= 1'b0;
        end else begin
            o_done       <= go_resp;
            o_misaligned <= go_resp && mis;
            o_outOfRange <= go_resp && oor;
            o_rdata      <= (go_resp && !i_write && !mis && !oor) ? ld_data : 32'h0;
            case (state)
                IDLE: if (i_req) begin
                    state <= WAIT_CYCLES == 0 ? RESP : WAIT;
                    cnt   <= WLOAD;
                end
                WAIT: begin
                    state <= cnt == 4'd0 ? RESP : WAIT;
                    cnt   <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized check of dmem_responder against a byte-array memory model
module tb_dmem_responder;
    localparam int NI = 3;
    int          waits  [NI] = '{1, 3, 0};
    logic [31:0] bases  [NI] = '{32'h0, 32'h100, 32'h0};
    int          depths [NI] = '{1024, 64, 16};

    logic        clk = 1'b0;
    logic        rstn  [NI];
    logic        req   [NI];
    logic        wr    [NI];
    logic [31:0] addr  [NI];
    logic [31:0] wdat  [NI];
    logic [1:0]  size  [NI];
    logic [31:0] rdata [NI];
    logic        stall [NI];
    logic        done  [NI];
    logic        mis   [NI];
    logic        oor   [NI];
    logic [7:0]  rm [NI][4096];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS(g == 0 ? 1024 : g == 1 ? 64 : 16),
            .BASE_ADDR  (g == 1 ? 32'h100 : 32'h0),
            .WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 3 : 0)
        ) u_dut (
            .clk         (clk),
            .reset_x     (rstn[g]),
            .i_req       (req[g]),
            .i_write     (wr[g]),
            .i_addr      (addr[g]),
            .i_wdata     (wdat[g]),
            .i_memSize   (size[g]),
            .o_rdata     (rdata[g]),
            .o_stall     (stall[g]),
            .o_done      (done[g]),
            .o_misaligned(mis[g]),
            .o_outOfRange(oor[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one full access: model prediction, drive, wait for completion, compare
    task automatic do_access(input int k, input bit w, input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] wd, output logic [31:0] gd, output logic gm, output logic go);
        int n, lat;
        longint off;
        bit em, eo;
        logic [31:0] ed;
        n   = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        em  = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        off = longint'(a) - longint'(bases[k]);
        eo  = off < 0 || off >= longint'(depths[k]) * 4;
        ed  = 32'h0;
        if (!em && !eo)
            for (int i = 0; i < n; i++)
                if (w) rm[k][int'(off) + i] = wd[8*i +: 8];
                else   ed[8*i +: 8] = rm[k][int'(off) + i];
        @(negedge clk);
        req[k] = 1'b1; wr[k] = w; addr[k] = a; size[k] = sz; wdat[k] = wd;
        #1;
        chk("stall_accept", stall[k], 1'b1);
        lat = 0;
        while (!done[k] && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!done[k]) begin
                chk("stall_wait", stall[k], 1'b1);
                chk("rdata_idle", rdata[k], 32'h0);
            end
        end
        chk("latency", lat, waits[k] + 1);
        chk("stall_resp", stall[k], 1'b0);
        chk("misaligned", mis[k], em);
        chk("outofrange", oor[k], eo);
        if (!w || em || eo) chk("rdata", rdata[k], ed);
        gd = rdata[k]; gm = mis[k]; go = oor[k];
        req[k] = 1'b0;
    endtask

    initial begin
        logic [31:0] gd, a, keep;
        logic gm, go;
        int r;
        for (int k = 0; k < NI; k++) begin
            rstn[k] = 1'b0; req[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'h0; wdat[k] = 32'h0; size[k] = 2'd0;
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_done", done[k], 1'b0);
            chk("rst_stall", stall[k], 1'b0);
            chk("rst_rdata", rdata[k], 32'h0);
            chk("rst_flags", {mis[k], oor[k]}, 2'b00);
            rstn[k] = 1'b1;
        end
        for (int k = 0; k < NI; k++)
            for (int j = 0; j < 16; j++)
                do_access(k, 1'b1, bases[k] + 32'(j * 4), 2'd2, $urandom, gd, gm, go);

        do_access(0, 1'b1, 32'h10, 2'd2, 32'hDEADBEEF, gd, gm, go);
        do_access(0, 1'b0, 32'h10, 2'd2, 32'h0, gd, gm, go);
        chk("word_rt", gd, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++)
            do_access(0, 1'b1, 32'h20 + 32'(i), 2'd0, 32'(8'h11 * (i + 1)), gd, gm, go);
        do_access(0, 1'b0, 32'h22, 2'd1, 32'h0, gd, gm, go);
        chk("half_load", gd, 32'h00004433);
        do_access(0, 1'b0, 32'h20, 2'd2, 32'h0, gd, gm, go);
        chk("word_bytes", gd, 32'h44332211);
        do_access(0, 1'b1, 32'h04, 2'd2, 32'hCAFEF00D, gd, gm, go);
        do_access(0, 1'b1, 32'h06, 2'd2, 32'h12345678, gd, gm, go);
        chk("mis_flag", gm, 1'b1);
        do_access(0, 1'b0, 32'h04, 2'd2, 32'h0, gd, gm, go);
        chk("mis_nostore", gd, 32'hCAFEF00D);
        do_access(0, 1'b0, 32'h1000, 2'd2, 32'h0, gd, gm, go);
        chk("oor_flags", {gm, go}, 2'b01);
        chk("oor_rdata", gd, 32'h0);

        keep = {rm[1][11], rm[1][10], rm[1][9], rm[1][8]};
        @(negedge clk);
        req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h108; size[1] = 2'd2; wdat[1] = ~keep;
        @(negedge clk);
        chk("abort_stall_pre", stall[1], 1'b1);
        rstn[1] = 1'b0;
        #1;
        chk("abort_outs", {stall[1], done[1], mis[1], oor[1]}, 4'b0000);
        chk("abort_rdata", rdata[1], 32'h0);
        req[1] = 1'b0;
        @(negedge clk);
        rstn[1] = 1'b1;
        do_access(1, 1'b0, 32'h108, 2'd2, 32'h0, gd, gm, go);
        chk("abort_nostore", gd, keep);

        @(negedge clk);
        req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 32'h0; size[2] = 2'd2;
        #1;
        chk("b2b_stall0", stall[2], 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("b2b_done", done[2], i % 2 == 0);
            chk("b2b_stall", stall[2], i % 2 != 0);
            if (i % 2 == 0) chk("b2b_rdata", rdata[2], {rm[2][3], rm[2][2], rm[2][1], rm[2][0]});
        end
        req[2] = 1'b0;

        for (int k = 0; k < NI; k++)
            for (int t = 0; t < 60; t++) begin
                r = $urandom_range(0, 9);
                if (r == 0) a = bases[k] + 32'(depths[k] * 4) + 32'($urandom_range(0, 15));
                else if (r == 1 && bases[k] >= 4) a = bases[k] - 32'($urandom_range(1, 4));
                else a = bases[k] + 32'($urandom_range(0, 63));
                do_access(k, 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), $urandom, gd, gm, go);
            end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
